// File: rtl/sobel_window_loader.sv
// sobel_window_loader: builds 3x4 pixel windows from a column-major byte
// stream and presents them to the Sobel gx/gy window blocks.
module sobel_window_loader #(
  parameter int IMG_WIDTH = 640
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [7:0]       pixel_in,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic [11:0][7:0] data_buffer,
  output logic             enable_calc,
  output logic             stripe_done,
  output logic             busy
);
  localparam int NWIN = (IMG_WIDTH - 2) / 2;
  localparam int WW = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic [WW-1:0] LAST_WIN = WW'(NWIN - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, CALC, SHIFT, DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    byte_cnt;
  logic [WW-1:0] win_cnt;
  logic          accept;
  logic          last_byte;
  logic          last_win;
  logic [3:0]    wr_idx;

  assign accept    = pixel_valid && pixel_ready;
  assign last_byte = (state == FILL) ? (byte_cnt == 4'd11)
                                     : (byte_cnt == 4'd5);
  assign last_win  = (win_cnt == LAST_WIN);

  // k%3 picks the row, k/3 the column; SHIFT refills columns 2..3
  always_comb begin
    wr_idx = (byte_cnt % 4'd3) * 4'd4 + byte_cnt / 4'd3;
    if (state == SHIFT) wr_idx = wr_idx + 4'd2;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (start) state_nxt = FILL;
      FILL, SHIFT: if (accept && last_byte) state_nxt = CALC;
      CALC:        state_nxt = last_win ? DONE : SHIFT;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pixel_ready = 1'b0;
    enable_calc = 1'b0;
    stripe_done = 1'b0;
    busy        = 1'b1;
    unique case (state)
      IDLE:        busy = 1'b0;
      FILL, SHIFT: pixel_ready = 1'b1;
      CALC:        enable_calc = 1'b1;
      DONE:        stripe_done = 1'b1;
      default:     busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt    <= '0;
      win_cnt     <= '0;
      data_buffer <= '0;
    end else begin
      if (state == IDLE && start) begin
        byte_cnt <= '0;
        win_cnt  <= '0;
      end
      if (accept) begin
        data_buffer[wr_idx] <= pixel_in;
        byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
      end
      if (state == CALC && !last_win) begin
        win_cnt <= win_cnt + WW'(1);
        for (int r = 0; r < 3; r++) begin
          data_buffer[r*4]   <= data_buffer[r*4+2];
          data_buffer[r*4+1] <= data_buffer[r*4+3];
        end
      end
    end
  end
endmodule
